// File: rtl/if_fetch.sv
// Instruction fetch front end: accepts PC addresses, issues single-outstanding
// memory requests and buffers returned instructions with their PC for decode.
module if_fetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_hold_n,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_pc,
  input  logic              id_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t            state, state_next;
  logic              req_next;
  logic              push, pop, launch;
  logic [CW-1:0]     count, eff;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [ADDR_W-1:0] pc_store [DEPTH];
  logic [DATA_W-1:0] instr_store [DEPTH];

  assign id_valid = (count != '0);
  assign id_pc    = pc_store[rd_ptr];
  assign id_instr = instr_store[rd_ptr];

  // eff reserves the FIFO slot for the in-flight request, so a push never overflows
  always_comb begin
    push   = (state == WAIT) && mem_ack && !flush;
    pop    = id_valid && id_ready && !flush;
    eff    = count + CW'(push) - CW'(pop);
    launch = !flush && (eff < CW'(DEPTH)) &&
             ((state == IDLE) || ((state == WAIT) && mem_ack));
    pc_hold_n  = !rst && (flush || launch);
    state_next = state;
    req_next   = mem_req;
    case (state)
      IDLE: begin
        if (launch) begin
          state_next = WAIT;
          req_next   = 1'b1;
        end
      end
      WAIT: begin
        if (launch) begin
          state_next = WAIT;
          req_next   = 1'b1;
        end else if (mem_ack) begin
          state_next = IDLE;
          req_next   = 1'b0;
        end else if (flush) begin
          state_next = DROP;
        end
      end
      DROP: begin
        if (mem_ack) begin
          state_next = IDLE;
          req_next   = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      state   <= state_next;
      mem_req <= req_next;
      if (launch) mem_addr <= pc_addr;
    end
  end

  // A flush empties the queue; stale storage stays behind but is masked by id_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_store[i]    <= '0;
        instr_store[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_store[wr_ptr]    <= mem_addr;
        instr_store[wr_ptr] <= mem_rdata;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= eff;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: a PC register and a random-latency memory drive the DUT,
// and a transaction-level model (busy flag, queue) predicts every output.
module tb_if_fetch;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] pc_addr;
  logic              pc_hold_n;
  logic              flush;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              id_valid;
  logic [DATA_W-1:0] id_instr;
  logic [ADDR_W-1:0] id_pc;
  logic              id_ready;

  if_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .pc_hold_n(pc_hold_n),
    .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc(id_pc), .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  int tests = 0;
  int failed = 0;

  // Reference model state
  entry_t            q[$];
  bit                m_busy;
  bit                m_discard;
  logic [ADDR_W-1:0] m_addr;
  logic [ADDR_W-1:0] pc_reg;

  // Stimulus knobs
  int lat_min, lat_max, lat, wait_cnt, ready_pct;
  bit spurious;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_busy    = 1'b0;
    m_discard = 1'b0;
    m_addr    = '0;
    pc_reg    = '0;
    wait_cnt  = 0;
    lat       = lat_min;
  endtask

  task automatic reset_checks();
    check("rst_pc_hold_n", pc_hold_n, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_id_valid", id_valid, 0);
    check("rst_id_pc", id_pc, 0);
    check("rst_id_instr", id_instr, 0);
  endtask

  // One clock cycle: drive at the falling edge, compare 1 time unit later, advance the model
  task automatic step(input bit f, input logic [ADDR_W-1:0] tgt);
    bit exp_valid, resp, push, pop, issue;
    int space;
    @(negedge clk);
    flush    = f;
    id_ready = ($urandom_range(99) < ready_pct);
    pc_addr  = pc_reg;
    if (mem_req) begin
      if (wait_cnt >= lat) begin
        mem_ack  = 1'b1;
        wait_cnt = 0;
        lat      = $urandom_range(lat_max, lat_min);
      end else begin
        mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ack  = spurious && ($urandom_range(3) == 0);
      wait_cnt = 0;
    end
    mem_rdata = $urandom;
    #1;
    check("mem_req", mem_req, m_busy);
    if (m_busy) check("mem_addr", mem_addr, m_addr);
    exp_valid = (q.size() > 0);
    check("id_valid", id_valid, exp_valid);
    if (exp_valid) begin
      check("id_pc", id_pc, q[0].pc);
      check("id_instr", id_instr, q[0].instr);
    end
    resp  = m_busy && mem_ack;
    push  = resp && !m_discard && !f;
    pop   = exp_valid && id_ready && !f;
    space = q.size() + int'(push) - int'(pop);
    issue = !f && (space < DEPTH) && (!m_busy || (resp && !m_discard));
    check("pc_hold_n", pc_hold_n, f || issue);
    if (f) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{pc: m_addr, instr: mem_rdata});
    end
    if (issue) begin
      m_busy    = 1'b1;
      m_discard = 1'b0;
      m_addr    = pc_reg;
    end else if (resp) begin
      m_busy    = 1'b0;
      m_discard = 1'b0;
    end else if (f && m_busy) begin
      m_discard = 1'b1;
    end
    if (pc_hold_n) pc_reg = f ? tgt : pc_reg + 32'd4;
  endtask

  task automatic set_knobs(input int lmin, input int lmax, input int rdy, input bit sp);
    lat_min   = lmin;
    lat_max   = lmax;
    ready_pct = rdy;
    spurious  = sp;
    if (!mem_req) lat = lmin;
  endtask

  initial begin
    bit found;
    rst = 1'b1; flush = 1'b0; id_ready = 1'b0; mem_ack = 1'b0;
    mem_rdata = '0; pc_addr = '0;
    set_knobs(0, 0, 100, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    reset_checks();
    @(posedge clk); #1;
    rst = 1'b0;

    // Stream with zero-wait memory
    for (int i = 0; i < 20; i++) step(1'b0, '0);

    // Wait states: ack in the third cycle of each request
    set_knobs(2, 2, 100, 0);
    for (int i = 0; i < 12; i++) step(1'b0, '0);

    // Backpressure: fill the queue, then drain
    set_knobs(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1'b0, '0);
    ready_pct = 100;
    for (int i = 0; i < 10; i++) step(1'b0, '0);

    // Flush while a slow request is outstanding, then a flush coincident with ack
    set_knobs(3, 3, 100, 0);
    for (int i = 0; i < 2; i++) step(1'b0, '0);
    step(1'b1, 32'h100);
    for (int i = 0; i < 10; i++) step(1'b0, '0);
    set_knobs(0, 0, 100, 0);
    for (int i = 0; i < 3; i++) step(1'b0, '0);
    step(1'b1, 32'h200);
    for (int i = 0; i < 6; i++) step(1'b0, '0);

    // Randomized mix of latency, backpressure, flushes and stray acks
    set_knobs(0, 3, 60, 1);
    for (int i = 0; i < 2500; i++)
      step($urandom_range(99) < 8, $urandom & 32'h0000_fffc);

    // Asynchronous reset while a request is outstanding
    set_knobs(3, 3, 100, 0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, '0);
      found = (mem_req === 1'b1) && (q.size() > 0 || i > 4);
    end
    if (!found) begin
      tests++;
      failed++;
      $error("[TB] FAIL wait_mem_req observed=timeout expected=mem_req");
    end
    #2;
    rst = 1'b1; flush = 1'b0; mem_ack = 1'b0;
    #1;
    reset_checks();
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    set_knobs(0, 2, 80, 1);
    for (int i = 0; i < 30; i++) step(1'b0, '0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Consumer end of the PC address interface.
- Each cycle it decides whether to accept the address the PC register presents. It drives `pc_hold_n` back so the PC register only advances or takes a jump when the address has been consumed.
- Accepted addresses go out as single-outstanding requests on an instruction-memory req/ack bus. Returned instructions are buffered with their PC in a small FIFO feeding the decode stage.
- Sits between the PC register and instruction memory / ID stage.

Parameters:
- ADDR_W, 32, address width (matches PC register width)
- DATA_W, 32, instruction width
- DEPTH, 2, FIFO entries (power of two, >=2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- pc_addr  in  ADDR_W  address presented by the PC register
- pc_hold_n  out  1  1 = address consumed or jump allowed this cycle (PC advances/jumps next edge); 0 = PC must hold
- flush  in  1  redirect request, tied to the jump-enable that drives the PC register
- mem_req  out  1  instruction memory request, registered
- mem_addr  out  ADDR_W  request address, registered, stable while mem_req=1
- mem_ack  in  1  response valid, single-cycle pulse
- mem_rdata  in  DATA_W  instruction data, valid with mem_ack
- id_valid  out  1  FIFO head valid
- id_instr  out  DATA_W  head instruction
- id_pc  out  ADDR_W  head instruction address
- id_ready  in  1  ID stage accepts head this cycle

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, mem_req=0, mem_addr=0, FIFO empty.
  - id_valid=0; id_instr=0 and id_pc=0 (storage cleared).
  - pc_hold_n=0 while rst=1.
- States:
  - IDLE: nothing outstanding.
  - WAIT: request outstanding, response wanted.
  - DROP: request outstanding, response to be discarded.
- Bus rules:
  - mem_req rises the cycle after launch and stays 1, with mem_addr constant, until the cycle mem_ack=1.
  - mem_ack is ignored when mem_req=0.
  - mem_ack is legal in the first cycle mem_req=1.
- Counts per cycle:
  - push = (state==WAIT && mem_ack && !flush).
  - pop = (id_valid && id_ready && !flush).
  - eff = count + push - pop.
- Launch condition = !flush && eff<DEPTH && (state==IDLE || (state==WAIT && mem_ack)).
- On launch:
  - pc_hold_n=1; mem_addr<=pc_addr; mem_req<=1; next state WAIT.
  - Zero-wait memory therefore sustains 1 instruction/cycle.
- Push writes {pc = mem_addr, instr = mem_rdata} at the FIFO tail.
  - With WAIT, mem_ack and no launch: mem_req<=0, next state IDLE.
- Otherwise, with no flush: pc_hold_n=0.
- One outstanding request maximum. The slot reservation in eff guarantees a push never overflows.
- Flush cycle (flush=1), in order of precedence:
  - pc_hold_n=1 so the PC register takes the jump.
  - No launch; pc_addr is not sampled.
  - FIFO cleared at the edge, so id_valid=0 next cycle. No pop is counted.
  - IDLE -> IDLE.
  - WAIT with mem_ack -> data discarded, mem_req<=0, IDLE.
  - WAIT without mem_ack -> DROP, mem_req held.
  - DROP -> DROP.
  - The first launch of the target address occurs the cycle after flush at the earliest.
- DROP:
  - pc_hold_n=0 unless flush.
  - On mem_ack: discard data, mem_req<=0, IDLE. No launch in the same cycle.
- FIFO:
  - id_* show the head combinationally from storage.
  - Full with id_ready=0: no launch, pc_hold_n=0, PC stalls.
  - Pointers wrap modulo DEPTH.
  - Pop and push in the same cycle are both honoured.
- rst asserted mid-WAIT or mid-DROP: immediate return to reset state. The in-flight bus response is the memory side's responsibility (it is reset by the same rst).
- No alignment check: pc_addr is passed through unmodified.

Test Plan:
- Stream, zero-wait memory: rst released, pc_addr 0x0,0x4,0x8..., mem_ack every cycle mem_req=1, id_ready=1.
  - pc_hold_n=1 every cycle after the first.
  - id_pc sequence 0x0,0x4,0x8 with matching id_instr.
  - One instruction per cycle after a 2-cycle latency.
- Wait states: mem_ack 3 cycles after mem_req for addr 0x10.
  - mem_req/mem_addr=0x10 stable for 3 cycles.
  - pc_hold_n=0 for 2 cycles, then 1 in the ack cycle.
  - id_valid with id_pc=0x10 next cycle.
- Backpressure: DEPTH=2, id_ready=0, zero-wait ack.
  - Exactly 2 entries (0x0,0x4) fill, then no further launch; pc_hold_n stays 0.
  - Set id_ready=1: 0x0 pops, then fetch of 0x8 launches.
- Flush during WAIT: request 0x20 outstanding, flush=1 with pc_addr pointing at target 0x100.
  - pc_hold_n=1, FIFO empties, state DROP.
  - Ack for 0x20 discarded.
  - Next launch has mem_addr=0x100; no id_pc=0x20 ever appears.
- Flush coincident with mem_ack: data discarded, no DROP.
  - Launch of 0x100 the following cycle; id_valid=0 until its ack.
- Reset mid-WAIT: rst=1 asynchronously while mem_req=1.
  - mem_req=0, id_valid=0, pc_hold_n=0 immediately.
  - After release, the first launch takes the PC reset address.
